// File: rtl/alu_mdu.sv
// alu_mdu: single-cycle ALU with iterative unsigned multiply and divide.
// Ports: clk, reset (sync, active-low), start, A, B, ALUOp -> C, HI, busy, done, dz.
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUOp,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] HI,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam int S  = $clog2(WIDTH);
  localparam int CW = S + 1;

  typedef enum logic {IDLE, CALC} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_div;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_p_hi;
  logic [WIDTH-1:0] r_p_lo;
  logic [WIDTH-1:0] r_c;
  logic [WIDTH-1:0] r_h;
  logic             r_busy;
  logic             r_done;
  logic             r_dz;

  logic [S-1:0]     w_amt;
  logic [WIDTH-1:0] w_res;
  logic             w_multi;
  logic             w_div;
  logic             w_bz;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_nhi;
  logic [WIDTH-1:0] w_nlo;

  assign w_amt   = B[S-1:0];
  assign w_multi = ALUOp[2] & ALUOp[1];
  assign w_div   = (ALUOp == 3'b111);
  assign w_bz    = (B == '0);

  always_comb begin
    w_res = '0;
    case (ALUOp)
      3'b000:  w_res = A + B;
      3'b001:  w_res = A - B;
      3'b010:  w_res = A & B;
      3'b011:  w_res = A | B;
      3'b100:  w_res = A >> w_amt;
      3'b101:  w_res = $signed(A) >>> w_amt;
      default: w_res = '0;
    endcase
  end

  // Multiply: conditional add into the high half, then shift the
  // whole {hi,lo} pair right; multiplier bits drain out of lo.
  assign w_sum = {1'b0, r_p_hi} + (r_p_lo[0] ? {1'b0, r_a} : '0);

  // Divide: shift the next dividend bit into the remainder and
  // subtract the divisor when it fits (restoring).  The remainder
  // stays below the divisor, so the difference fits in WIDTH bits.
  assign w_sh   = {r_p_hi, r_p_lo[WIDTH-1]};
  assign w_ge   = (w_sh >= {1'b0, r_a});
  assign w_diff = w_sh[WIDTH-1:0] - r_a;

  always_comb begin
    w_nhi = w_sum[WIDTH:1];
    w_nlo = {w_sum[0], r_p_lo[WIDTH-1:1]};
    if (r_div) begin
      w_nhi = w_ge ? w_diff : w_sh[WIDTH-1:0];
      w_nlo = {r_p_lo[WIDTH-2:0], w_ge};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_a     <= '0;
      r_p_hi  <= '0;
      r_p_lo  <= '0;
      r_c     <= '0;
      r_h     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (!w_multi) begin
              r_c    <= w_res;
              r_h    <= '0;
              r_dz   <= 1'b0;
              r_done <= 1'b1;
            end else if (w_div && w_bz) begin
              r_c    <= '1;
              r_h    <= A;
              r_dz   <= 1'b1;
              r_done <= 1'b1;
            end else begin
              r_div   <= w_div;
              r_a     <= w_div ? B : A;
              r_p_lo  <= w_div ? A : B;
              r_p_hi  <= '0;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_p_hi <= w_nhi;
          r_p_lo <= w_nlo;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_c     <= w_nlo;
            r_h     <= w_nhi;
            r_dz    <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign C    = r_c;
  assign HI   = r_h;
  assign busy = r_busy;
  assign done = r_done;
  assign dz   = r_dz;

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed + random checks of alu_mdu at WIDTH=32 and WIDTH=8.
// Both instances share stimulus; each is compared to an arithmetic model.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] a;
  logic [63:0] b;
  logic [2:0]  op;

  logic [31:0] c32, h32;
  logic        bsy32, dn32, dz32;
  logic [7:0]  c8, h8;
  logic        bsy8, dn8, dz8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .start(start),
    .A(a[31:0]), .B(b[31:0]), .ALUOp(op),
    .C(c32), .HI(h32), .busy(bsy32), .done(dn32), .dz(dz32)
  );

  alu_mdu #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start),
    .A(a[7:0]), .B(b[7:0]), .ALUOp(op),
    .C(c8), .HI(h8), .busy(bsy8), .done(dn8), .dz(dz8)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input int w, input logic [2:0] o,
                                input logic [63:0] xa, xb,
                                output logic [63:0] c, h,
                                output logic z);
    logic [63:0] m, aa, bb, p;
    int sh;
    m  = (64'd1 << w) - 64'd1;
    aa = xa & m;
    bb = xb & m;
    c  = '0;
    h  = '0;
    z  = 1'b0;
    sh = int'(bb % 64'(w));
    case (o)
      3'd0: c = (aa + bb) & m;
      3'd1: c = (aa - bb) & m;
      3'd2: c = aa & bb;
      3'd3: c = aa | bb;
      3'd4: c = aa >> sh;
      3'd5: begin
        c = aa >> sh;
        if (aa[w-1]) c = c | (m & ~(m >> sh));
      end
      3'd6: begin
        p = aa * bb;
        c = p & m;
        h = p >> w;
      end
      default: begin
        if (bb == 0) begin
          c = m;
          h = aa;
          z = 1'b1;
        end else begin
          c = aa / bb;
          h = aa % bb;
        end
      end
    endcase
  endfunction

  task automatic run(input logic [2:0] o, input logic [63:0] xa, xb);
    logic [63:0] ec32, eh32, ec8, eh8;
    logic        ez32, ez8;
    logic [63:0] cc32, ch32, cc8, ch8;
    logic        cz32, cz8;
    bit          m32, m8;
    int          n32, n8, l32, l8, kmax;
    model(32, o, xa, xb, ec32, eh32, ez32);
    model(8, o, xa, xb, ec8, eh8, ez8);
    m32  = (o == 3'd6) || (o == 3'd7 && xb[31:0] != 0);
    m8   = (o == 3'd6) || (o == 3'd7 && xb[7:0] != 0);
    kmax = m32 ? 35 : 3;
    n32 = 0; n8 = 0; l32 = -1; l8 = -1;
    cc32 = '0; ch32 = '0; cz32 = 1'b0;
    cc8 = '0; ch8 = '0; cz8 = 1'b0;
    @(negedge clk);
    op = o; a = xa; b = xb; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= kmax; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("busy32_e0", 64'(bsy32), 64'(m32));
        chk("busy8_e0", 64'(bsy8), 64'(m8));
      end
      // inputs wander and extra starts arrive while both are busy
      start = (m32 && m8 && k >= 1 && k <= 5);
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      op = 3'($urandom_range(0, 7));
      if (dn32) begin
        n32++; l32 = k; cc32 = 64'(c32); ch32 = 64'(h32); cz32 = dz32;
      end
      if (dn8) begin
        n8++; l8 = k; cc8 = 64'(c8); ch8 = 64'(h8); cz8 = dz8;
      end
    end
    start = 1'b0;
    chk("ndone32", 64'(n32), 64'd1);
    chk("ndone8", 64'(n8), 64'd1);
    chk("lat32", 64'(l32), m32 ? 64'd32 : 64'd0);
    chk("lat8", 64'(l8), m8 ? 64'd8 : 64'd0);
    chk("C32", cc32, ec32);
    chk("HI32", ch32, eh32);
    chk("dz32", 64'(cz32), 64'(ez32));
    chk("C8", cc8, ec8);
    chk("HI8", ch8, eh8);
    chk("dz8", 64'(cz8), 64'(ez8));
    chk("C32_hold", 64'(c32), ec32);
    chk("HI8_hold", 64'(h8), eh8);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int nd;
    logic [2:0]  ro;
    logic [63:0] ra, rb;
    reset = 1'b0; start = 1'b1; op = 3'd6;
    a = 64'd7; b = 64'd9;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_C32", 64'(c32), 64'd0);
    chk("rst_HI32", 64'(h32), 64'd0);
    chk("rst_busy32", 64'(bsy32), 64'd0);
    chk("rst_done32", 64'(dn32), 64'd0);
    chk("rst_dz32", 64'(dz32), 64'd0);
    chk("rst_busy8", 64'(bsy8), 64'd0);
    chk("rst_done8", 64'(dn8), 64'd0);

    reset = 1'b1; op = 3'd0; a = 64'd5; b = 64'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("first_done", 64'(dn32), 64'd1);
    chk("first_C", 64'(c32), 64'd14);

    run(3'd0, 64'hFFFFFFFF, 64'd1);
    chk("add_wrap", 64'(c32), 64'h0);
    run(3'd4, 64'hFFF000F3, 64'd6);
    chk("srl_C", 64'(c32), 64'h03FFC003);
    run(3'd5, 64'hFFF000F3, 64'd6);
    chk("sra_C", 64'(c32), 64'hFFFFC003);
    run(3'd6, 64'hFFFFFFFF, 64'd2);
    chk("mul_C", 64'(c32), 64'hFFFFFFFE);
    chk("mul_HI", 64'(h32), 64'h1);
    run(3'd7, 64'd100, 64'd7);
    chk("div_C", 64'(c32), 64'd14);
    chk("div_HI", 64'(h32), 64'd2);
    run(3'd7, 64'd5, 64'd0);
    chk("dz_C", 64'(c32), 64'hFFFFFFFF);
    chk("dz_HI", 64'(h32), 64'd5);
    chk("dz_flag", 64'(dz32), 64'd1);

    // single-cycle ops back to back
    op = 3'd1; a = 64'd10; b = 64'd3; start = 1'b1;
    @(negedge clk);
    chk("b2b_done1", 64'(dn32), 64'd1);
    chk("b2b_C1", 64'(c32), 64'd7);
    op = 3'd2; a = 64'd6; b = 64'd3;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_done2", 64'(dn32), 64'd1);
    chk("b2b_C2", 64'(c32), 64'd2);
    @(negedge clk);
    chk("b2b_idle", 64'(dn32), 64'd0);

    // start held during the done cycle of a multiply is accepted
    op = 3'd6; a = 64'd3; b = 64'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && !dn32; i++) @(negedge clk);
    chk("mb2b_done", 64'(dn32), 64'd1);
    chk("mb2b_C", 64'(c32), 64'd15);
    op = 3'd0; a = 64'd1; b = 64'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mb2b_next_done", 64'(dn32), 64'd1);
    chk("mb2b_next_C", 64'(c32), 64'd2);

    // reset in the middle of a multiply
    op = 3'd6; a = 64'hFFFF; b = 64'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort_busy", 64'(bsy32), 64'd0);
    chk("abort_done", 64'(dn32), 64'd0);
    chk("abort_C", 64'(c32), 64'd0);
    chk("abort_HI", 64'(h32), 64'd0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dn32 || dn8) nd++;
    end
    chk("abort_nodone", 64'(nd), 64'd0);
    run(3'd6, 64'h0000_1234_89AB_CDEF, 64'h0000_0000_7654_3210);

    repeat (24) begin
      ro = 3'($urandom_range(0, 7));
      ra = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       rb = 64'd0;
        1:       rb = 64'($urandom_range(1, 20));
        default: rb = {$urandom, $urandom};
      endcase
      run(ro, ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; legal values 8, 16, 32, 64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-004 start  input  1  request; operands and ALUOp captured on the edge where start=1 and busy=0.
REQ-005 A  input  WIDTH  operand A.
REQ-006 B  input  WIDTH  operand B; also the shift amount source.
REQ-007 ALUOp  input  3  operation select.
REQ-008 C  output  WIDTH  primary result (sum/difference/logic/shift/product low/quotient).
REQ-009 HI  output  WIDTH  secondary result (product high/remainder); 0 for ops 000-101.
REQ-010 busy  output  1  multi-cycle operation in progress.
REQ-011 done  output  1  one-cycle pulse; C/HI/dz valid and updated in that cycle.
REQ-012 dz  output  1  divide-by-zero flag of the last completed op.

Function
REQ-013 ALUOp: 000 add, 001 sub, 010 and, 011 or, 100 srl A>>B[S-1:0], 101 sra A>>>B[S-1:0] (S=log2 WIDTH), 110 unsigned multiply, 111 unsigned divide.
REQ-014 Add/sub wrap modulo 2^WIDTH; no carry/overflow output.
REQ-015 Ops 000-101: single-cycle; start sampled at edge E0 -> done=1, C valid, HI=0, dz=0 from E0; busy stays 0.
REQ-016 Op 110: iterative shift-add, one bit per cycle; busy=1 from E0; at edge E_WIDTH busy->0, done->1, {HI,C}=A*B (2*WIDTH bits).
REQ-017 Op 111, B!=0: restoring division, one bit per cycle, same timing as REQ-016; C=A/B, HI=A%B, dz=0.
REQ-018 Op 111, B==0: no iteration; at E0 done=1, C=all ones, HI=A, dz=1, busy stays 0.
REQ-019 FSM states IDLE, CALC; IDLE->CALC on accepted start with op 110/111 (B!=0); CALC->IDLE when iteration counter reaches WIDTH; counter width log2(WIDTH)+1.
REQ-020 start while busy=1 ignored; no queuing; in-flight op and captured operands unaffected by A/B/ALUOp changes.
REQ-021 Back-to-back: start accepted on the same edge done is asserted for a single-cycle op; for multi-cycle ops, next start accepted on edge E_WIDTH+1 earliest (busy=0 in cycle after E_WIDTH... i.e., start high during done cycle is accepted).
REQ-022 done is high exactly one cycle per accepted start; never asserted otherwise.
REQ-023 C, HI, dz hold their value between completions; they change only with done.

Reset
REQ-024 reset=0 at a rising edge: C=0, HI=0, busy=0, done=0, dz=0, FSM=IDLE, counter=0.
REQ-025 reset mid-operation aborts the op with no done pulse; reset overrides a simultaneous start.
REQ-026 First start accepted on the first edge with reset=1.

Verification (WIDTH=32)
REQ-027 A=0xFFFFFFFF, B=1, op 000, start 1 cycle -> next cycle C=0x00000000, HI=0, done=1 for one cycle, busy=0.
REQ-028 A=0xFFF000F3, B=6: op 100 -> C=0x03FFC003; op 101 -> C=0xFFFFC003; each done one cycle after start.
REQ-029 A=0xFFFFFFFF, B=2, op 110 -> busy=1 for 32 cycles, done at edge 32 with C=0xFFFFFFFE, HI=0x00000001; start pulses during busy produce no extra done.
REQ-030 A=100, B=7, op 111 -> done at edge 32, C=14, HI=2, dz=0; then A=5, B=0, op 111 -> done next cycle, C=0xFFFFFFFF, HI=5, dz=1.
REQ-031 op 110 started, reset=0 at cycle 10 -> busy=0, done never asserted, C=HI=0; start after reset release completes normally.
REQ-032 Re-run REQ-027..REQ-030 at WIDTH=8 with operands truncated to 8 bits; results match modulo-256 reference model, latency 8.
